delay_sweep_ctrl: RTL and testbench

DELAY_SWEEP_CTRL -- requirements
Module: delay_sweep_ctrl

---
 rtl/delay_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_delay_sweep_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sweep_ctrl.sv
// Sweeps a table of two-input vector pairs into an external device, measuring the
// cycles from launch until its output changes and emitting one record per test.
`timescale 1ns/1ps
module delay_sweep_ctrl #(
  parameter int unsigned NUM_TESTS = 5,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned SETTLE    = 10,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_we,
  input  logic [3:0]      vec_addr,
  input  logic [3:0]      vec_data,
  output logic            dut_a,
  output logic            dut_b,
  input  logic            dut_c,
  output logic            busy,
  output logic            done,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [3:0]      rec_test,
  output logic [TS_W-1:0] rec_t0,
  output logic [TS_W-1:0] rec_t1,
  output logic            rec_c0,
  output logic            rec_c1,
  output logic [7:0]      rec_delay,
  output logic            rec_timeout
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TBL_D = 16;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    LAUNCH  = 3'd2,
    MEASURE = 3'd3,
    EMIT    = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t state;
  state_t state_nx;

  logic [VEC_W-1:0] tbl [TBL_D];
  logic [TS_W-1:0]  ts;
  logic [SET_W-1:0] set_cnt;
  logic [CNT_W-1:0] meas_cnt;

  logic settle_last_c, meas_last_c, idx_last_c, c_change_c;
  logic idx_clr_c, idx_inc_c, set_clr_c, set_inc_c;
  logic drv_init_c, drv_final_c, c0_cap_c, t0_cap_c;
  logic meas_clr_c, meas_inc_c, meas_exit_c, tbl_we_c;
  logic done_nx_c, busy_nx_c, valid_nx_c;
  logic [IDX_W-1:0] idx_nx_c;
  logic [VEC_W-1:0] vec_sel_c;

  assign settle_last_c = (set_cnt == SET_W'(SETTLE - 1));
  assign meas_last_c   = (meas_cnt == CNT_W'(TIMEOUT - 1));
  assign idx_last_c    = (rec_test == IDX_W'(NUM_TESTS - 1));
  assign c_change_c    = (dut_c != rec_c0);

  // Vector for the index that will be current next cycle, so stimulus lines up with state
  assign idx_nx_c  = idx_clr_c ? '0 : (idx_inc_c ? rec_test + IDX_W'(1) : rec_test);
  assign vec_sel_c = tbl[idx_nx_c];

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = INIT;
      INIT:    if (settle_last_c) state_nx = LAUNCH;
      LAUNCH:  state_nx = MEASURE;
      MEASURE: if (c_change_c || meas_last_c) state_nx = EMIT;
      EMIT:    if (rec_ready) state_nx = NEXT;
      NEXT:    state_nx = idx_last_c ? IDLE : INIT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin : out_decode
    idx_clr_c   = 1'b0;
    idx_inc_c   = 1'b0;
    set_clr_c   = 1'b0;
    set_inc_c   = 1'b0;
    drv_init_c  = 1'b0;
    drv_final_c = 1'b0;
    c0_cap_c    = 1'b0;
    t0_cap_c    = 1'b0;
    meas_clr_c  = 1'b0;
    meas_inc_c  = 1'b0;
    meas_exit_c = 1'b0;
    tbl_we_c    = 1'b0;
    done_nx_c   = 1'b0;
    case (state)
      IDLE: begin
        tbl_we_c = vec_we;
        if (start) begin
          idx_clr_c  = 1'b1;
          set_clr_c  = 1'b1;
          drv_init_c = 1'b1;
        end
      end
      INIT: begin
        if (settle_last_c) begin
          c0_cap_c    = 1'b1;
          drv_final_c = 1'b1;
        end else begin
          set_inc_c  = 1'b1;
          drv_init_c = 1'b1;
        end
      end
      LAUNCH: begin
        t0_cap_c   = 1'b1;
        meas_clr_c = 1'b1;
      end
      MEASURE: begin
        if (c_change_c || meas_last_c) meas_exit_c = 1'b1;
        else                           meas_inc_c  = 1'b1;
      end
      NEXT: begin
        if (idx_last_c) begin
          done_nx_c = 1'b1;
        end else begin
          idx_inc_c  = 1'b1;
          set_clr_c  = 1'b1;
          drv_init_c = 1'b1;
        end
      end
      default: ;
    endcase
    busy_nx_c  = (state_nx != IDLE);
    valid_nx_c = (state_nx == EMIT);
  end

  // Table has no reset so its contents survive a sweep abort
  always_ff @(posedge clk) begin : tbl_write
    if (tbl_we_c) tbl[vec_addr] <= vec_data;
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      ts          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rec_valid   <= 1'b0;
      dut_a       <= 1'b0;
      dut_b       <= 1'b0;
      rec_test    <= '0;
      rec_t0      <= '0;
      rec_t1      <= '0;
      rec_c0      <= 1'b0;
      rec_c1      <= 1'b0;
      rec_delay   <= '0;
      rec_timeout <= 1'b0;
      set_cnt     <= '0;
      meas_cnt    <= '0;
    end else begin
      ts        <= ts + TS_W'(1);
      busy      <= busy_nx_c;
      done      <= done_nx_c;
      rec_valid <= valid_nx_c;
      rec_test  <= idx_nx_c;
      if (set_clr_c)      set_cnt <= '0;
      else if (set_inc_c) set_cnt <= set_cnt + SET_W'(1);
      if (drv_init_c) begin
        dut_a <= vec_sel_c[3];
        dut_b <= vec_sel_c[2];
      end else if (drv_final_c) begin
        dut_a <= vec_sel_c[1];
        dut_b <= vec_sel_c[0];
      end
      if (c0_cap_c) rec_c0 <= dut_c;
      if (t0_cap_c) rec_t0 <= ts;
      if (meas_clr_c)      meas_cnt <= '0;
      else if (meas_inc_c) meas_cnt <= meas_cnt + CNT_W'(1);
      // A change wins over timeout when both coincide on the last measure edge
      if (meas_exit_c) begin
        rec_t1      <= ts;
        rec_c1      <= dut_c;
        rec_delay   <= c_change_c ? meas_cnt + CNT_W'(1) : CNT_W'(TIMEOUT);
        rec_timeout <= !c_change_c;
      end
    end
  end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Scoreboard bench for delay_sweep_ctrl: instance a uses a zero-delay AND gate with a
// one-cycle timeout, instance b a four-cycle delayed AND gate with a 4-bit timestamp.
`timescale 1ns/1ps
module tb_delay_sweep_ctrl;

  typedef struct {
    logic [3:0]  test;
    logic        c0;
    logic        c1;
    logic [7:0]  dly;
    logic        to;
    logic [15:0] dt;
    logic        chk;
    logic [15:0] t0;
    logic [15:0] t1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_vec_we, a_dut_a, a_dut_b, a_dut_c, a_busy, a_done;
  logic        a_rec_valid, a_rec_ready, a_rec_c0, a_rec_c1, a_rec_timeout;
  logic [3:0]  a_vec_addr, a_vec_data, a_rec_test;
  logic [15:0] a_rec_t0, a_rec_t1, a_dt;
  logic [7:0]  a_rec_delay;

  logic        b_rst, b_start, b_vec_we, b_dut_a, b_dut_b, b_dut_c, b_busy, b_done;
  logic        b_rec_valid, b_rec_ready, b_rec_c0, b_rec_c1, b_rec_timeout;
  logic [3:0]  b_vec_addr, b_vec_data, b_rec_test;
  logic [3:0]  b_rec_t0, b_rec_t1, b_dt;
  logic [7:0]  b_rec_delay;
  logic [3:0]  b_pipe = '0;
  logic [3:0]  ts_b = '0;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int dones_a = 0;
  int dones_b = 0;

  delay_sweep_ctrl #(.NUM_TESTS(5), .TS_W(16), .SETTLE(10), .TIMEOUT(1)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .vec_we(a_vec_we), .vec_addr(a_vec_addr),
    .vec_data(a_vec_data), .dut_a(a_dut_a), .dut_b(a_dut_b), .dut_c(a_dut_c),
    .busy(a_busy), .done(a_done), .rec_valid(a_rec_valid), .rec_ready(a_rec_ready),
    .rec_test(a_rec_test), .rec_t0(a_rec_t0), .rec_t1(a_rec_t1), .rec_c0(a_rec_c0),
    .rec_c1(a_rec_c1), .rec_delay(a_rec_delay), .rec_timeout(a_rec_timeout)
  );

  delay_sweep_ctrl #(.NUM_TESTS(3), .TS_W(4), .SETTLE(10), .TIMEOUT(63)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .vec_we(b_vec_we), .vec_addr(b_vec_addr),
    .vec_data(b_vec_data), .dut_a(b_dut_a), .dut_b(b_dut_b), .dut_c(b_dut_c),
    .busy(b_busy), .done(b_done), .rec_valid(b_rec_valid), .rec_ready(b_rec_ready),
    .rec_test(b_rec_test), .rec_t0(b_rec_t0), .rec_t1(b_rec_t1), .rec_c0(b_rec_c0),
    .rec_c1(b_rec_c1), .rec_delay(b_rec_delay), .rec_timeout(b_rec_timeout)
  );

  // Devices under measurement
  assign a_dut_c = a_dut_a & a_dut_b;
  always @(posedge clk) b_pipe <= {b_pipe[2:0], b_dut_a & b_dut_b};
  assign b_dut_c = b_pipe[3];

  // Reference free-running timestamp for instance b
  always @(posedge clk) ts_b <= b_rst ? 4'd0 : ts_b + 4'd1;

  assign a_dt = a_rec_t1 - a_rec_t0;
  assign b_dt = b_rec_t1 - b_rec_t0;

  function automatic exp_t mk(input logic [3:0] test, input logic c0, input logic c1,
                              input logic [7:0] dly, input logic to, input logic [15:0] dt,
                              input logic chk, input logic [15:0] t0, input logic [15:0] t1);
    exp_t e;
    e.test = test; e.c0 = c0; e.c1 = c1; e.dly = dly; e.to = to;
    e.dt = dt; e.chk = chk; e.t0 = t0; e.t1 = t1;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic cmp_rec(input string nm, input exp_t e, input logic [3:0] test,
                         input logic c0, input logic c1, input logic [7:0] dly, input logic to,
                         input logic [15:0] dt, input logic [15:0] t0, input logic [15:0] t1);
    logic ok;
    checks++;
    ok = (test === e.test) && (c0 === e.c0) && (c1 === e.c1) && (dly === e.dly) &&
         (to === e.to) && (dt === e.dt);
    if (e.chk) ok = ok && (t0 === e.t0) && (t1 === e.t1);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got test=%0d c0=%0b c1=%0b delay=%0d timeout=%0b dt=%0d t0=%0d t1=%0d; expected test=%0d c0=%0b c1=%0b delay=%0d timeout=%0b dt=%0d t0=%0d t1=%0d",
               nm, test, c0, c1, dly, to, dt, t0, t1,
               e.test, e.c0, e.c1, e.dly, e.to, e.dt, e.t0, e.t1);
    end
  endtask

  // Monitor: compare every presented record against the queue head, pop on transfer
  always @(negedge clk) begin
    if (a_done) dones_a++;
    if (b_done) dones_b++;
    if (a_rec_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL rec_a_unexpected: got test=%0d with no record pending", a_rec_test);
      end else begin
        cmp_rec("rec_a", qa[0], a_rec_test, a_rec_c0, a_rec_c1, a_rec_delay, a_rec_timeout,
                a_dt, a_rec_t0, a_rec_t1);
        if (a_rec_ready) void'(qa.pop_front());
      end
    end
    if (b_rec_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rec_b_unexpected: got test=%0d with no record pending", b_rec_test);
      end else begin
        cmp_rec("rec_b", qb[0], b_rec_test, b_rec_c0, b_rec_c1, b_rec_delay, b_rec_timeout,
                16'(b_dt), 16'(b_rec_t0), 16'(b_rec_t1));
        if (b_rec_ready) void'(qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (a_done) break;
    end
    check("done_a", 64'(a_done), 64'(1));
    check("busy_at_done_a", 64'(a_busy), 64'(0));
  endtask

  task automatic wait_done_b(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (b_done) break;
    end
    check(nm, 64'(b_done), 64'(1));
    check({nm, "_busy"}, 64'(b_busy), 64'(0));
  endtask

  task automatic push_b_sweep(input logic chk_first, input int n);
    qb.push_back(mk(4'd0, 1'b0, 1'b1, 8'd4, 1'b0, 16'd4, chk_first, 16'd14, 16'd2));
    if (n > 1) qb.push_back(mk(4'd1, 1'b1, 1'b0, 8'd4, 1'b0, 16'd4, 1'b0, 16'd0, 16'd0));
    if (n > 2) qb.push_back(mk(4'd2, 1'b0, 1'b1, 8'd4, 1'b0, 16'd4, 1'b0, 16'd0, 16'd0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] tab_a [5];
    logic [3:0] tab_b [4];
    logic [3:0] addr_b [4];
    tab_a  = '{4'hF, 4'h3, 4'hE, 4'h9, 4'h6};
    tab_b  = '{4'h3, 4'hC, 4'h3, 4'hF};
    addr_b = '{4'd0, 4'd1, 4'd2, 4'd5};
    a_rst = 1'b1; a_start = 1'b0; a_vec_we = 1'b0; a_vec_addr = '0; a_vec_data = '0;
    a_rec_ready = 1'b1;
    b_rst = 1'b1; b_start = 1'b0; b_vec_we = 1'b0; b_vec_addr = '0; b_vec_data = '0;
    b_rec_ready = 1'b1;
    tick(); tick();
    check("reset_a", 64'({a_busy, a_done, a_rec_valid, a_dut_a, a_dut_b, a_rec_test, a_rec_t0,
                          a_rec_t1, a_rec_c0, a_rec_c1, a_rec_delay, a_rec_timeout}), 64'(0));
    check("reset_b", 64'({b_busy, b_done, b_rec_valid, b_dut_a, b_dut_b, b_rec_test, b_rec_t0,
                          b_rec_t1, b_rec_c0, b_rec_c1, b_rec_delay, b_rec_timeout}), 64'(0));
    a_rst = 1'b0; b_rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      a_vec_we = 1'b1; a_vec_addr = 4'(i); a_vec_data = tab_a[i];
      if (i < 4) begin
        b_vec_we = 1'b1; b_vec_addr = addr_b[i]; b_vec_data = tab_b[i];
      end else begin
        b_vec_we = 1'b0;
      end
      tick();
    end
    a_vec_we = 1'b0; b_vec_we = 1'b0;

    // Instance a: zero-delay gate, five records
    qa.push_back(mk(4'd0, 1'b1, 1'b1, 8'd1, 1'b1, 16'd1, 1'b0, 16'd0, 16'd0));
    qa.push_back(mk(4'd1, 1'b0, 1'b1, 8'd1, 1'b0, 16'd1, 1'b0, 16'd0, 16'd0));
    qa.push_back(mk(4'd2, 1'b1, 1'b0, 8'd1, 1'b0, 16'd1, 1'b0, 16'd0, 16'd0));
    qa.push_back(mk(4'd3, 1'b0, 1'b0, 8'd1, 1'b1, 16'd1, 1'b0, 16'd0, 16'd0));
    qa.push_back(mk(4'd4, 1'b0, 1'b0, 8'd1, 1'b1, 16'd1, 1'b0, 16'd0, 16'd0));
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("busy_after_start_a", 64'(a_busy), 64'(1));
    wait_done_a();
    tick();
    check("done_count_a", 64'(dones_a), 64'(1));
    check("queue_empty_a", 64'(qa.size()), 64'(0));

    // Instance b sweep 1: launch of test0 lands at ts=14, stall on test1, busy pokes
    push_b_sweep(1'b1, 3);
    for (int i = 0; i < 40; i++) begin
      if (ts_b == 4'd3) break;
      tick();
    end
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("busy_after_start_b", 64'(b_busy), 64'(1));
    tick(); tick();
    b_start = 1'b1; b_vec_we = 1'b1; b_vec_addr = 4'd1; b_vec_data = 4'h3;
    tick();
    b_start = 1'b0; b_vec_we = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_rec_valid && b_rec_ready) break;
    end
    check("xfer_test0_b", 64'(b_rec_valid & b_rec_ready), 64'(1));
    tick();
    b_rec_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_rec_valid) break;
    end
    check("stall_valid_1_b", 64'(b_rec_valid), 64'(1));
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d_b", k), 64'(b_rec_valid), 64'(1));
    end
    tick();
    b_rec_ready = 1'b1;
    wait_done_b("done_sweep1_b");
    tick();
    check("done_count_sweep1_b", 64'(dones_b), 64'(1));
    check("queue_empty_sweep1_b", 64'(qb.size()), 64'(0));

    // Instance b sweep 2: reset during measure of test2
    push_b_sweep(1'b0, 2);
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qb.size() == 0) break;
    end
    check("records_before_abort_b", 64'(qb.size()), 64'(0));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_dut_a) break;
    end
    check("launch_test2_b", 64'({b_dut_a, b_dut_b}), 64'(3));
    tick(); tick();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    @(negedge clk);
    check("abort_outputs_b", 64'({b_busy, b_done, b_rec_valid, b_dut_a, b_dut_b, b_rec_test,
                                  b_rec_t0, b_rec_t1, b_rec_c0, b_rec_c1, b_rec_delay,
                                  b_rec_timeout}), 64'(0));
    tick();
    check("no_done_on_abort_b", 64'(dones_b), 64'(1));

    // Instance b sweep 3: rerun from test0 with the table intact
    push_b_sweep(1'b0, 3);
    b_start = 1'b1; tick(); b_start = 1'b0;
    wait_done_b("done_sweep3_b");
    tick();
    check("done_count_sweep3_b", 64'(dones_b), 64'(2));
    check("queue_empty_sweep3_b", 64'(qb.size()), 64'(0));
    check("queue_empty_end_a", 64'(qa.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
